// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator: bars, gradient, checkerboard, bouncing box.
// Latency 1 cycle (outputs registered from counter state); free-running, no backpressure.
module video_pattern_gen #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FRONT   = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BACK    = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FRONT   = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 33,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter int          BOX_SIZE  = 32,
    parameter logic [23:0] BOX_COLOR = 24'hFFFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  mode,
    output logic        video_de,
    output logic        video_hsync,
    output logic        video_vsync,
    output logic [23:0] video_data,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [HW-1:0] BX_MAX   = HW'(H_ACTIVE - BOX_SIZE);
    localparam logic [HW-1:0] BOX_H    = HW'(BOX_SIZE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [VW-1:0] BY_MAX   = VW'(V_ACTIVE - BOX_SIZE);
    localparam logic [VW-1:0] BOX_V    = VW'(BOX_SIZE);

    logic [HW-1:0] r_h_cnt, r_bx;
    logic [VW-1:0] r_v_cnt, r_by;
    logic          r_dx_neg, r_dy_neg;
    logic [1:0]    r_mode;

    logic          w_origin, w_active, w_hs_on, w_vs_on, w_in_box, w_box_step;
    logic [1:0]    w_mode;
    logic [2:0]    w_bar;
    logic [23:0]   w_bar_rgb, w_pix;

    // The mode sampled at the origin already applies to the origin pixel itself.
    assign w_origin   = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_mode     = w_origin ? mode : r_mode;
    assign w_active   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_on    = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
    assign w_vs_on    = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
    assign w_box_step = (r_h_cnt == H_ACT) && (r_v_cnt == V_ACT);
    assign w_in_box   = (r_h_cnt >= r_bx) && (r_h_cnt < r_bx + BOX_H) &&
                        (r_v_cnt >= r_by) && (r_v_cnt < r_by + BOX_V);

    // Bar index by threshold compare; anything past the 7th threshold stays in the last bar.
    always_comb begin
        w_bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (r_h_cnt >= HW'(k * BAR_W)) w_bar = 3'(k);
        end
        case (w_bar)
            3'd0:    w_bar_rgb = 24'hFFFFFF;
            3'd1:    w_bar_rgb = 24'hFFFF00;
            3'd2:    w_bar_rgb = 24'h00FFFF;
            3'd3:    w_bar_rgb = 24'h00FF00;
            3'd4:    w_bar_rgb = 24'hFF00FF;
            3'd5:    w_bar_rgb = 24'hFF0000;
            3'd6:    w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        case (w_mode)
            2'b00:   w_pix = w_bar_rgb;
            2'b01:   w_pix = {3{r_h_cnt[7:0]}};
            2'b10:   w_pix = (r_h_cnt[5] ~^ r_v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
            default: w_pix = w_in_box ? BOX_COLOR : 24'h000080;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_mode      <= 2'b00;
            r_bx        <= '0;
            r_by        <= '0;
            r_dx_neg    <= 1'b0;
            r_dy_neg    <= 1'b0;
            video_de    <= 1'b0;
            video_data  <= '0;
            frame_start <= 1'b0;
            video_hsync <= ~HSYNC_POL;
            video_vsync <= ~VSYNC_POL;
        end else begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end

            if (w_origin) r_mode <= mode;

            // Box moves at the start of vertical blanking so a frame never shows a torn box.
            if (w_box_step) begin
                if (!r_dx_neg && r_bx == BX_MAX) begin
                    r_dx_neg <= 1'b1;
                    r_bx     <= r_bx - HW'(1);
                end else if (r_dx_neg && r_bx == '0) begin
                    r_dx_neg <= 1'b0;
                    r_bx     <= HW'(1);
                end else begin
                    r_bx     <= r_dx_neg ? r_bx - HW'(1) : r_bx + HW'(1);
                end

                if (!r_dy_neg && r_by == BY_MAX) begin
                    r_dy_neg <= 1'b1;
                    r_by     <= r_by - VW'(1);
                end else if (r_dy_neg && r_by == '0) begin
                    r_dy_neg <= 1'b0;
                    r_by     <= VW'(1);
                end else begin
                    r_by     <= r_dy_neg ? r_by - VW'(1) : r_by + VW'(1);
                end
            end

            video_de    <= w_active;
            video_data  <= w_active ? w_pix : 24'h000000;
            frame_start <= w_origin;
            video_hsync <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
            video_vsync <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a reduced raster, every output cycle scored against a
// model that derives pixel coordinates, frame index and box position from the cycle count.
module tb_video_pattern_gen;

    localparam int   HA = 42, HF = 2, HS = 4, HB = 2;
    localparam int   VA = 36, VF = 1, VS = 2, VB = 1;
    localparam int   BOX = 34;
    localparam logic HPOL = 1'b0, VPOL = 1'b1;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   FRAME = HT * VT;
    localparam int   BW = HA / 8;
    localparam logic [23:0] BOXC = 24'hC0FFEE;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [23:0] data;
    } out_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        video_de, video_hsync, video_vsync, frame_start;
    logic [23:0] video_data;

    out_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n = 0;
    logic [1:0] frame_mode = 2'b00;
    logic [1:0] cur_mode;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
        .BOX_SIZE(BOX), .BOX_COLOR(BOXC)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .video_de(video_de), .video_hsync(video_hsync), .video_vsync(video_vsync),
        .video_data(video_data), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    // Bouncing position after f per-frame moves: a triangle wave between 0 and m.
    function automatic int tri_pos(input int f, input int m);
        int p;
        p = f % (2 * m);
        return (p <= m) ? p : 2 * m - p;
    endfunction

    function automatic logic [23:0] pixel(input int x, input int y, input int f, input logic [1:0] m);
        int bar, bx, by;
        case (m)
            2'b00: begin
                bar = x / BW;
                if (bar > 7) bar = 7;
                case (bar)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'b01: return {3{8'(x % 256)}};
            2'b10: return (((x / 32) % 2) == ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            default: begin
                bx = tri_pos(f, HA - BOX);
                by = tri_pos(f, VA - BOX);
                return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? BOXC : 24'h000080;
            end
        endcase
    endfunction

    task automatic step(input logic r, input logic [1:0] m);
        out_t e;
        int pos, x, y, f;
        reset = r;
        mode  = m;
        if (r) begin
            e.de = 1'b0; e.fs = 1'b0; e.data = 24'h0;
            e.hs = ~HPOL; e.vs = ~VPOL;
            n = 0;
        end else begin
            pos = n % FRAME;
            x = pos % HT;
            y = pos / HT;
            f = n / FRAME;
            if (pos == 0) frame_mode = m;
            e.de   = (x < HA) && (y < VA);
            e.data = e.de ? pixel(x, y, f, frame_mode) : 24'h0;
            e.fs   = (pos == 0);
            e.hs   = (x >= HA + HF && x < HA + HF + HS) ? HPOL : ~HPOL;
            e.vs   = (y >= VA + VF && y < VA + VF + VS) ? VPOL : ~VPOL;
            n++;
        end
        @(posedge clock);
        sb.push_back(e);
        #1;
    endtask

    task automatic run_until(input int target, input logic [1:0] m, input bool_rand);
        while (n < target) begin
            if (bool_rand && $urandom_range(0, 99) == 0) cur_mode = 2'($urandom_range(0, 3));
            step(1'b0, bool_rand ? cur_mode : m);
        end
    endtask

    always @(negedge clock) begin
        out_t exp_o, act_o;
        if (sb.size() > 0) begin
            exp_o = sb.pop_front();
            act_o = {video_de, video_hsync, video_vsync, frame_start, video_data};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL pixel t=%0t got de=%b hs=%b vs=%b fs=%b data=%h want de=%b hs=%b vs=%b fs=%b data=%h",
                         $time, act_o.de, act_o.hs, act_o.vs, act_o.fs, act_o.data,
                         exp_o.de, exp_o.hs, exp_o.vs, exp_o.fs, exp_o.data);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mode  = 2'b00;
        cur_mode = 2'b00;
        repeat (3) step(1'b1, 2'b00);
        // Bars, then a mid-frame switch to checkerboard that must wait for the next frame.
        run_until(10 * HT, 2'b00, 1'b0);
        run_until(2 * FRAME + 5, 2'b10, 1'b0);
        run_until(3 * FRAME, 2'b01, 1'b0);
        cur_mode = 2'b01;
        run_until(5 * FRAME + 15 * HT + 20, 2'b00, 1'b1);
        // Reset mid-line, mid-frame: everything restarts from the origin with the box at 0,0.
        step(1'b1, 2'b11);
        step(1'b1, 2'b11);
        run_until(22 * FRAME, 2'b11, 1'b0);
        step(1'b1, 2'b11);
        run_until(FRAME + 3 * HT, 2'b11, 1'b0);
        repeat (3) @(posedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameters H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FRONT, H_SYNC, H_BACK, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 SHALL have parameters V_FRONT, V_SYNC, V_BACK, defaults 10, 2, 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HSYNC_POL and VSYNC_POL, default 0 each, giving the asserted sync level (0 = active-low).
REQ-006 SHALL have parameter BOX_SIZE, default 32, bouncing-box edge length; BOX_SIZE <= min(H_ACTIVE, V_ACTIVE).
REQ-007 SHALL have parameter BOX_COLOR, default 24'hFFFFFF, box fill colour.
REQ-008 SHALL have port clock, input, 1 bit, pixel clock; all logic is in this single domain.
REQ-009 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-010 SHALL have port mode, input, 2 bits: 00 colour bars, 01 gradient, 10 checkerboard, 11 bouncing box.
REQ-011 SHALL have port video_de, output, 1 bit, active-video flag.
REQ-012 SHALL have ports video_hsync and video_vsync, output, 1 bit each, sync at the parameter polarity.
REQ-013 SHALL have port video_data, output, 24 bits, {R,G,B}, 8 bits each.
REQ-014 SHALL have port frame_start, output, 1 bit, one-cycle pulse coincident with pixel (0,0).

Function
REQ-015 SHALL run h_cnt over 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters), wrapping to 0; v_cnt advances on each h wrap, over 0..V_TOTAL-1, wrapping to 0; widths are $clog2 of the totals.
REQ-016 SHALL place active video at h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-017 SHALL assert hsync for h_cnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC), and vsync likewise on v_cnt for whole lines.
REQ-018 SHALL register all outputs; each output reflects the counter state of the previous cycle, giving a latency of 1.
REQ-019 SHALL drive video_data = 0 whenever de = 0.
REQ-020 SHALL latch mode only when h_cnt = 0 and v_cnt = 0; a mid-frame mode change takes effect at the next frame.
REQ-021 In colour-bar mode, SHALL show 8 bars of width H_ACTIVE/8 (integer) in the order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; the last bar absorbs any remainder.
REQ-022 In gradient mode, SHALL set R = G = B = h_cnt[7:0] (wraps every 256 px).
REQ-023 In checkerboard mode, SHALL output FFFFFF when h_cnt[5] XNOR v_cnt[5] is 1, otherwise 000000.
REQ-024 In bouncing-box mode, SHALL output BOX_COLOR when bx <= h_cnt < bx+BOX_SIZE and by <= v_cnt < by+BOX_SIZE, otherwise 000080.
REQ-025 SHALL update box position once per frame, at h_cnt = H_ACTIVE, v_cnt = V_ACTIVE (start of blanking), in every mode.
REQ-026 SHALL compute the X box update as: if dx=+1 and bx = H_ACTIVE-BOX_SIZE, set dx=-1 and bx=bx-1; if dx=-1 and bx = 0, set dx=+1 and bx=1; otherwise bx=bx+dx. Y uses the same rule with V_ACTIVE and dy; the box never leaves the active area.

Reset
REQ-027 On reset, the following SHALL take effect at the next clock: h_cnt = v_cnt = 0, de = 0, frame_start = 0, video_data = 0, hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, bx = by = 0, dx = dy = +1, latched mode = 00.
REQ-028 Reset asserted mid-line or mid-frame SHALL abort the frame with no partial-state carry-over; mode is re-latched at the first (0,0) after release.
REQ-029 In the first cycle after reset release, the counters SHALL be at (0,0); in the following cycle, de = 1, frame_start = 1, and the pixel is for (0,0).

Verification
REQ-030 Reset release with mode=00 -> 2nd cycle: de=1, frame_start=1, data FFFFFF; data FFFF00 first appears at pixel 80; data 000000 appears at pixels 560..639.
REQ-031 Default timing over 2 frames -> 640 de cycles per line, line period 800, hsync low for 96 cycles starting at h=656, vsync low on lines 490-491, frame period 420000 cycles, frame_start once per frame.
REQ-032 mode 01 -> pixel x=300 is 2C2C2C; mode 10 -> (0,0) FFFFFF, (32,0) 000000, (32,32) FFFFFF.
REQ-033 mode switched 00->10 at line 100 -> current frame stays colour bars; next frame is checkerboard.
REQ-034 mode 11 run for 610 frames -> bx reaches 608, then 607 with dx=-1; by reverses at 448; box pixel BOX_COLOR, background 000080.
REQ-035 Reset pulsed at h=300, v=200 -> outputs reach reset values the next cycle; frame restarts at (0,0) with bx = by = 0.
